// File: rtl/reset_sequencer.sv
// Staged reset generator: asynchronous assertion, synchronised deassertion,
// a hold period, then a staggered release of N_OUT reset domains with soft-reset replay.
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int N_OUT       = 4,
  parameter int STAGE_GAP   = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             soft_rst_req,
  output logic [N_OUT-1:0] rst_out,
  output logic             init_done,
  output logic             seq_busy,
  output logic [CNT_W-1:0] soft_rst_cnt
);

  typedef enum logic [1:0] {SYNC, HOLD, RELEASE, RUN} state_t;

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int GAP_W  = $clog2(STAGE_GAP + 1);
  localparam int IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_OUT - 1);

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg, sync_next;
  logic [HOLD_W-1:0]      hold_cnt_reg, hold_cnt_next;
  logic [GAP_W-1:0]       gap_cnt_reg, gap_cnt_next;
  logic [IDX_W-1:0]       stage_idx_reg, stage_idx_next;
  logic [N_OUT-1:0]       rst_out_reg, rst_out_next;
  logic                   init_done_reg, init_done_next;
  logic                   seq_busy_reg, seq_busy_next;
  logic [CNT_W-1:0]       soft_cnt_reg, soft_cnt_next;

  logic                   soft_accept;
  logic                   sync_clear;
  logic [N_OUT-1:0]       next_bit_sel;

  assign soft_accept = soft_rst_req && (state_reg != SYNC);
  assign sync_next   = {sync_reg[SYNC_STAGES-2:0], 1'b0};
  // Leave SYNC on the edge where the last synchroniser stage takes its 0.
  assign sync_clear  = ~sync_reg[SYNC_STAGES-2];

  // One-hot select of the domain that follows the one most recently released.
  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_sel
    if (gi == 0) begin : g_first
      assign next_bit_sel[gi] = 1'b0;
    end else begin : g_rest
      assign next_bit_sel[gi] = (stage_idx_reg == IDX_W'(gi - 1));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= SYNC;
      sync_reg      <= '1;
      hold_cnt_reg  <= '0;
      gap_cnt_reg   <= '0;
      stage_idx_reg <= '0;
      rst_out_reg   <= '1;
      init_done_reg <= 1'b0;
      seq_busy_reg  <= 1'b1;
      soft_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      sync_reg      <= sync_next;
      hold_cnt_reg  <= hold_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
      stage_idx_reg <= stage_idx_next;
      rst_out_reg   <= rst_out_next;
      init_done_reg <= init_done_next;
      seq_busy_reg  <= seq_busy_next;
      soft_cnt_reg  <= soft_cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (soft_accept) begin
      state_next = HOLD;
    end else begin
      case (state_reg)
        SYNC:    if (sync_clear) state_next = HOLD;
        HOLD:    if (hold_cnt_reg == HOLD_LAST) state_next = RELEASE;
        RELEASE: if (stage_idx_reg == IDX_LAST) state_next = RUN;
        default: state_next = RUN;
      endcase
    end
  end

  always_comb begin
    hold_cnt_next  = hold_cnt_reg;
    gap_cnt_next   = gap_cnt_reg;
    stage_idx_next = stage_idx_reg;
    rst_out_next   = rst_out_reg;
    init_done_next = init_done_reg;
    soft_cnt_next  = soft_cnt_reg;
    seq_busy_next  = (state_next != RUN);
    if (soft_accept) begin
      rst_out_next   = '1;
      init_done_next = 1'b0;
      hold_cnt_next  = '0;
      gap_cnt_next   = '0;
      stage_idx_next = '0;
      if (soft_cnt_reg != '1) soft_cnt_next = soft_cnt_reg + 1'b1;
    end else begin
      case (state_reg)
        SYNC: hold_cnt_next = '0;
        HOLD: begin
          if (hold_cnt_reg == HOLD_LAST) begin
            rst_out_next[0] = 1'b0;
            gap_cnt_next    = '0;
            stage_idx_next  = '0;
          end else begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
        end
        RELEASE: begin
          if (stage_idx_reg == IDX_LAST) begin
            init_done_next = 1'b1;
          end else if (gap_cnt_reg == GAP_LAST) begin
            gap_cnt_next   = '0;
            stage_idx_next = stage_idx_reg + 1'b1;
            rst_out_next   = rst_out_reg & ~next_bit_sel;
          end else begin
            gap_cnt_next = gap_cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rst_out      = rst_out_reg;
  assign init_done    = init_done_reg;
  assign seq_busy     = seq_busy_reg;
  assign soft_rst_cnt = soft_cnt_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: the driver queues hand-computed expectations tagged with a cycle,
// the monitor pops and compares them on the falling edge of that cycle.
module tb_reset_sequencer;

    logic clock = 1'b0;
    int   cyc = 0;

    logic reset_a = 1'b0, soft_a = 1'b0;
    logic [3:0] rst_a; logic init_a, busy_a; logic [7:0] cnt_a;

    logic reset_b = 1'b0, soft_b = 1'b0;
    logic [3:0] rst_b; logic init_b, busy_b; logic [1:0] cnt_b;

    logic reset_c = 1'b0, soft_c = 1'b0;
    logic [0:0] rst_c; logic init_c, busy_c; logic [7:0] cnt_c;

    reset_sequencer dut_a (
        .clock(clock), .reset(reset_a), .soft_rst_req(soft_a),
        .rst_out(rst_a), .init_done(init_a), .seq_busy(busy_a), .soft_rst_cnt(cnt_a));

    reset_sequencer #(.CNT_W(2)) dut_b (
        .clock(clock), .reset(reset_b), .soft_rst_req(soft_b),
        .rst_out(rst_b), .init_done(init_b), .seq_busy(busy_b), .soft_rst_cnt(cnt_b));

    reset_sequencer #(.N_OUT(1), .HOLD_CYCLES(1), .SYNC_STAGES(2)) dut_c (
        .clock(clock), .reset(reset_c), .soft_rst_req(soft_c),
        .rst_out(rst_c), .init_done(init_c), .seq_busy(busy_c), .soft_rst_cnt(cnt_c));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         dut;
        logic [3:0] rst;
        logic       init;
        logic       busy;
        logic [7:0] cnt;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic expect_at(input int dut, input int c, input logic [3:0] r,
                             input logic i, input logic b, input logic [7:0] n, input string nm);
        exp_t e;
        e.cyc = c; e.dut = dut; e.rst = r; e.init = i; e.busy = b; e.cnt = n; e.name = nm;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_now(input int dut, input logic [3:0] r, input logic i,
                             input logic b, input logic [7:0] n, input string nm);
        logic [3:0] g_rst;
        logic       g_init, g_busy;
        logic [7:0] g_cnt;
        case (dut)
            0: begin g_rst = rst_a; g_init = init_a; g_busy = busy_a; g_cnt = cnt_a; end
            1: begin g_rst = rst_b; g_init = init_b; g_busy = busy_b; g_cnt = {6'b0, cnt_b}; end
            default: begin g_rst = {3'b0, rst_c}; g_init = init_c; g_busy = busy_c; g_cnt = cnt_c; end
        endcase
        n_cmp++;
        if (g_rst !== r || g_init !== i || g_busy !== b || g_cnt !== n) begin
            n_bad++;
            $display("FAIL %s dut%0d t=%0t (async): got rst=%b init=%b busy=%b cnt=%0d, want rst=%b init=%b busy=%b cnt=%0d",
                     nm, dut, $time, g_rst, g_init, g_busy, g_cnt, r, i, b, n);
        end else begin
            $display("ok   %s dut%0d t=%0t (async): rst=%b init=%b busy=%b cnt=%0d",
                     nm, dut, $time, g_rst, g_init, g_busy, g_cnt);
        end
    endtask

    // Monitor
    initial begin
        exp_t       cur;
        logic [3:0] a_rst;
        logic       a_init, a_busy;
        logic [7:0] a_cnt;
        forever begin
            @(negedge clock);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                cur = q.pop_front();
                case (cur.dut)
                    0: begin a_rst = rst_a; a_init = init_a; a_busy = busy_a; a_cnt = cnt_a; end
                    1: begin a_rst = rst_b; a_init = init_b; a_busy = busy_b; a_cnt = {6'b0, cnt_b}; end
                    default: begin a_rst = {3'b0, rst_c}; a_init = init_c; a_busy = busy_c; a_cnt = cnt_c; end
                endcase
                n_cmp++;
                if (cur.cyc != cyc || a_rst !== cur.rst || a_init !== cur.init ||
                    a_busy !== cur.busy || a_cnt !== cur.cnt) begin
                    n_bad++;
                    $display("FAIL %s dut%0d cyc %0d (due %0d): got rst=%b init=%b busy=%b cnt=%0d, want rst=%b init=%b busy=%b cnt=%0d",
                             cur.name, cur.dut, cyc, cur.cyc, a_rst, a_init, a_busy, a_cnt,
                             cur.rst, cur.init, cur.busy, cur.cnt);
                end else begin
                    $display("ok   %s dut%0d cyc %0d: rst=%b init=%b busy=%b cnt=%0d",
                             cur.name, cur.dut, cyc, a_rst, a_init, a_busy, a_cnt);
                end
            end
        end
    end

    // Driver
    initial begin
        int c0;
        int s;
        exp_t left;
        #2;
        reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
        #1;
        check_now(0, 4'b1111, 0, 1, 0, "a_por_async");
        check_now(1, 4'b1111, 0, 1, 0, "b_por_async");
        check_now(2, 4'b0001, 0, 1, 0, "c_por_async");
        expect_at(0, 2, 4'b1111, 0, 1, 0, "a_in_reset");
        expect_at(2, 2, 4'b0001, 0, 1, 0, "c_in_reset");
        tick(5);

        // Power-on sequence with default parameters
        c0 = cyc; reset_a = 1'b0;
        expect_at(0, c0 + 1,  4'b1111, 0, 1, 0, "a_e1");
        expect_at(0, c0 + 17, 4'b1111, 0, 1, 0, "a_e17");
        expect_at(0, c0 + 18, 4'b1110, 0, 1, 0, "a_e18");
        expect_at(0, c0 + 21, 4'b1110, 0, 1, 0, "a_e21");
        expect_at(0, c0 + 22, 4'b1100, 0, 1, 0, "a_e22");
        expect_at(0, c0 + 26, 4'b1000, 0, 1, 0, "a_e26");
        expect_at(0, c0 + 29, 4'b1000, 0, 1, 0, "a_e29");
        expect_at(0, c0 + 30, 4'b0000, 0, 1, 0, "a_e30");
        expect_at(0, c0 + 31, 4'b0000, 1, 0, 0, "a_e31");
        tick(33);

        // Single-cycle soft reset from RUN
        s = cyc + 1; soft_a = 1'b1;
        expect_at(0, s,      4'b1111, 0, 1, 1, "a_soft1_s");
        expect_at(0, s + 15, 4'b1111, 0, 1, 1, "a_soft1_s15");
        expect_at(0, s + 16, 4'b1110, 0, 1, 1, "a_soft1_s16");
        expect_at(0, s + 28, 4'b0000, 0, 1, 1, "a_soft1_s28");
        expect_at(0, s + 29, 4'b0000, 1, 0, 1, "a_soft1_s29");
        tick(1); soft_a = 1'b0;
        tick(31);

        // Soft reset held for three edges
        s = cyc + 1; soft_a = 1'b1;
        expect_at(0, s,      4'b1111, 0, 1, 2, "a_soft3_s");
        expect_at(0, s + 1,  4'b1111, 0, 1, 3, "a_soft3_s1");
        expect_at(0, s + 2,  4'b1111, 0, 1, 4, "a_soft3_s2");
        expect_at(0, s + 17, 4'b1111, 0, 1, 4, "a_soft3_s17");
        expect_at(0, s + 18, 4'b1110, 0, 1, 4, "a_soft3_s18");
        expect_at(0, s + 30, 4'b0000, 0, 1, 4, "a_soft3_s30");
        expect_at(0, s + 31, 4'b0000, 1, 0, 4, "a_soft3_s31");
        tick(3); soft_a = 1'b0;
        tick(30);

        // Reset in RUN clears the soft-reset count asynchronously
        reset_a = 1'b1;
        #1;
        check_now(0, 4'b1111, 0, 1, 0, "a_rst_run_async");
        expect_at(0, cyc, 4'b1111, 0, 1, 0, "a_rst_run");
        tick(3);

        // Restart with soft_rst_req high during SYNC (ignored), then reset mid-release
        c0 = cyc; reset_a = 1'b0; soft_a = 1'b1;
        expect_at(0, c0 + 1,  4'b1111, 0, 1, 0, "a_sync_soft_e1");
        expect_at(0, c0 + 2,  4'b1111, 0, 1, 0, "a_sync_soft_e2");
        expect_at(0, c0 + 18, 4'b1110, 0, 1, 0, "a_r2_e18");
        expect_at(0, c0 + 22, 4'b1100, 0, 1, 0, "a_r2_e22");
        expect_at(0, c0 + 23, 4'b1100, 0, 1, 0, "a_r2_e23");
        tick(2); soft_a = 1'b0;
        tick(22);
        reset_a = 1'b1;
        #1;
        check_now(0, 4'b1111, 0, 1, 0, "a_rst_mid_release_async");
        expect_at(0, cyc, 4'b1111, 0, 1, 0, "a_rst_mid_release");
        tick(3);

        c0 = cyc; reset_a = 1'b0;
        expect_at(0, c0 + 1,  4'b1111, 0, 1, 0, "a_r3_e1");
        expect_at(0, c0 + 18, 4'b1110, 0, 1, 0, "a_r3_e18");
        expect_at(0, c0 + 22, 4'b1100, 0, 1, 0, "a_r3_e22");
        expect_at(0, c0 + 26, 4'b1000, 0, 1, 0, "a_r3_e26");
        expect_at(0, c0 + 30, 4'b0000, 0, 1, 0, "a_r3_e30");
        expect_at(0, c0 + 31, 4'b0000, 1, 0, 0, "a_r3_e31");
        tick(33);

        // Narrow counter saturation
        c0 = cyc; reset_b = 1'b0;
        expect_at(1, c0 + 30, 4'b0000, 0, 1, 0, "b_e30");
        expect_at(1, c0 + 31, 4'b0000, 1, 0, 0, "b_e31");
        tick(32);
        s = cyc + 1; soft_b = 1'b1;
        for (int k = 0; k < 5; k++)
            expect_at(1, s + k, 4'b1111, 0, 1, 8'((k < 3) ? k + 1 : 3), "b_sat");
        tick(5); soft_b = 1'b0;
        expect_at(1, s + 20, 4'b1110, 0, 1, 3, "b_after_s20");
        expect_at(1, s + 33, 4'b0000, 1, 0, 3, "b_after_s33");
        tick(35);

        // Single domain, one hold cycle
        c0 = cyc; reset_c = 1'b0;
        expect_at(2, c0 + 1, 4'b0001, 0, 1, 0, "c_e1");
        expect_at(2, c0 + 2, 4'b0001, 0, 1, 0, "c_e2");
        expect_at(2, c0 + 3, 4'b0000, 0, 1, 0, "c_e3");
        expect_at(2, c0 + 4, 4'b0000, 1, 0, 0, "c_e4");
        expect_at(2, c0 + 6, 4'b0000, 1, 0, 0, "c_e6");
        tick(8);

        tick(2);
        while (q.size() > 0) begin
            left = q.pop_front();
            n_bad++;
            $display("FAIL %s dut%0d: expectation due at cyc %0d never checked (now cyc %0d)",
                     left.name, left.dut, left.cyc, cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
